bht_counter_writer: RTL and testbench

//  Write side of the 128-entry, 2-bit branch-history table.
//  - Accepts branch-resolution updates (index, taken).
//  - Applies a saturating increment or decrement to the addressed counter.
//  - Exposes all counters on a flat bus that feeds the 128:1 2-bit read mux.
//  - Keeps update and saturation statistics for performance debug.

---
 rtl/bht_counter_writer_if.sv | 14 +
 rtl/bht_counter_writer.sv | 67 ++++++
 tb/tb_bht_counter_writer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bht_counter_writer_if.sv
// bht_counter_writer_if: update handshake and write-acknowledge bundle for the BHT writer
interface bht_counter_writer_if #(parameter int INDEX_W = 7);
  logic               update_valid;
  logic [INDEX_W-1:0] update_index;
  logic               update_taken;
  logic               update_ready;
  logic               write_ack;
  logic [INDEX_W-1:0] write_index;
  logic [1:0]         write_value;
  modport master(output update_valid, update_index, update_taken,
                 input update_ready, write_ack, write_index, write_value);
  modport slave(input update_valid, update_index, update_taken,
                output update_ready, write_ack, write_index, write_value);
endinterface

// File: rtl/bht_counter_writer.sv
// bht_counter_writer: two-stage saturating 2-bit counter write side of the branch-history table
module bht_counter_writer #(
  parameter int         ENTRIES   = 128,
  parameter int         INDEX_W   = 7,
  parameter logic [1:0] CTR_RESET = 2'b01,
  parameter int         COUNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  bht_counter_writer_if.slave  bus,
  output logic [2*ENTRIES-1:0] o_counters_flat,
  output logic [COUNT_W-1:0]   o_update_count,
  output logic [COUNT_W-1:0]   o_sat_count
);
  logic [1:0]         r_ctr [ENTRIES];
  logic               r_s1_valid;
  logic [INDEX_W-1:0] r_s1_index;
  logic               r_s1_taken;
  logic               r_ack;
  logic [INDEX_W-1:0] r_widx;
  logic [1:0]         r_wval;
  logic [COUNT_W-1:0] r_upd;
  logic [COUNT_W-1:0] r_sat;
  logic [1:0]         w_old;
  logic               w_rail;
  logic [1:0]         w_new;
  // Read from registers so a write landing on the previous edge is already visible
  always_comb begin
    w_old  = r_ctr[r_s1_index];
    w_rail = r_s1_taken ? (w_old == 2'b11) : (w_old == 2'b00);
    w_new  = w_rail ? w_old : (r_s1_taken ? w_old + 2'd1 : w_old - 2'd1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < ENTRIES; k++) r_ctr[k] <= CTR_RESET;
      r_s1_valid <= 1'b0;
      r_s1_index <= '0;
      r_s1_taken <= 1'b0;
      r_ack      <= 1'b0;
      r_widx     <= '0;
      r_wval     <= '0;
      r_upd      <= '0;
      r_sat      <= '0;
    end else begin
      r_s1_valid <= bus.update_valid;
      r_s1_index <= bus.update_index;
      r_s1_taken <= bus.update_taken;
      r_ack      <= r_s1_valid;
      if (r_s1_valid) begin
        r_ctr[r_s1_index] <= w_new;
        r_widx            <= r_s1_index;
        r_wval            <= w_new;
        if (~&r_upd) r_upd <= r_upd + 1'b1;
        if (w_rail && ~&r_sat) r_sat <= r_sat + 1'b1;
      end
    end
  end
  for (genvar i = 0; i < ENTRIES; i++) begin : g_flat
    assign o_counters_flat[2*i+:2] = r_ctr[i];
  end
  assign bus.update_ready = !reset;
  assign bus.write_ack    = r_ack;
  assign bus.write_index  = r_widx;
  assign bus.write_value  = r_wval;
  assign o_update_count   = r_upd;
  assign o_sat_count      = r_sat;
endmodule

// File: tb/tb_bht_counter_writer.sv
// tb_bht_counter_writer: table-driven directed checks of the BHT counter writer
module tb_bht_counter_writer;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] flat;
  logic [15:0]  uc;
  logic [15:0]  sc;
  logic [255:0] ef;
  int           n_cmp = 0;
  int           n_bad = 0;
  always #5 clock = ~clock;
  bht_counter_writer_if #(.INDEX_W(7)) bus();
  bht_counter_writer dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave),
    .o_counters_flat(flat),
    .o_update_count(uc),
    .o_sat_count(sc)
  );
  typedef struct {
    logic       v;
    logic [6:0] idx;
    logic       t;
    logic       ack;
    logic [6:0] widx;
    logic [1:0] wval;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  initial begin
    // Rows: inputs driven for one edge, outputs expected right after that edge
    tbl[0]  = '{1'b1, 7'd5,   1'b1, 1'b0, 7'd0,   2'd0};
    tbl[1]  = '{1'b0, 7'd0,   1'b0, 1'b1, 7'd5,   2'b10};
    tbl[2]  = '{1'b1, 7'd127, 1'b1, 1'b0, 7'd0,   2'd0};
    tbl[3]  = '{1'b1, 7'd127, 1'b1, 1'b1, 7'd127, 2'b10};
    tbl[4]  = '{1'b1, 7'd127, 1'b1, 1'b1, 7'd127, 2'b11};
    tbl[5]  = '{1'b1, 7'd127, 1'b1, 1'b1, 7'd127, 2'b11};
    tbl[6]  = '{1'b1, 7'd0,   1'b0, 1'b1, 7'd127, 2'b11};
    tbl[7]  = '{1'b1, 7'd64,  1'b1, 1'b1, 7'd0,   2'b00};
    tbl[8]  = '{1'b1, 7'd0,   1'b0, 1'b1, 7'd64,  2'b10};
    tbl[9]  = '{1'b1, 7'd64,  1'b1, 1'b1, 7'd0,   2'b00};
    tbl[10] = '{1'b0, 7'd0,   1'b0, 1'b1, 7'd64,  2'b11};
    tbl[11] = '{1'b0, 7'd0,   1'b0, 1'b0, 7'd0,   2'd0};
    bus.update_valid = 1'b0;
    bus.update_index = '0;
    bus.update_taken = 1'b0;
    reset = 1'b1;
    #1;
    chk("ready_in_reset", 256'(bus.update_ready), 256'd0);
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 256'(bus.update_ready), 256'd1);
    repeat (3) tick;
    chk("reset_flat", flat, {128{2'b01}});
    chk("reset_ack", 256'(bus.write_ack), 256'd0);
    chk("reset_widx", 256'(bus.write_index), 256'd0);
    chk("reset_wval", 256'(bus.write_value), 256'd0);
    chk("reset_ucnt", 256'(uc), 256'd0);
    chk("reset_scnt", 256'(sc), 256'd0);
    for (int r = 0; r < 12; r++) begin
      bus.update_valid = tbl[r].v;
      bus.update_index = tbl[r].idx;
      bus.update_taken = tbl[r].t;
      tick;
      chk($sformatf("row%0d_ack", r), 256'(bus.write_ack), 256'(tbl[r].ack));
      if (tbl[r].ack) begin
        chk($sformatf("row%0d_widx", r), 256'(bus.write_index), 256'(tbl[r].widx));
        chk($sformatf("row%0d_wval", r), 256'(bus.write_value), 256'(tbl[r].wval));
      end
      if (r == 1) begin
        ef = {128{2'b01}};
        ef[10+:2] = 2'b10;
        chk("single_flat", flat, ef);
      end
    end
    ef = {128{2'b01}};
    ef[10+:2]  = 2'b10;
    ef[254+:2] = 2'b11;
    ef[0+:2]   = 2'b00;
    ef[128+:2] = 2'b11;
    chk("table_flat", flat, ef);
    chk("table_ucnt", 256'(uc), 256'd9);
    chk("table_scnt", 256'(sc), 256'd3);
    // Reset lands on the edge that would have performed the captured write
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.update_valid = 1'b1;
    bus.update_index = 7'd9;
    bus.update_taken = 1'b1;
    tick;
    bus.update_valid = 1'b0;
    reset = 1'b1;
    tick;
    chk("rst_mid_ack0", 256'(bus.write_ack), 256'd0);
    reset = 1'b0;
    tick;
    chk("rst_mid_ack1", 256'(bus.write_ack), 256'd0);
    tick;
    chk("rst_mid_ack2", 256'(bus.write_ack), 256'd0);
    chk("rst_mid_flat", flat, {128{2'b01}});
    chk("rst_mid_ucnt", 256'(uc), 256'd0);
    chk("rst_mid_scnt", 256'(sc), 256'd0);
    // Stream updates up to all-ones minus one, then push past the top
    bus.update_valid = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      bus.update_index = 7'(i);
      bus.update_taken = i[0];
      tick;
    end
    bus.update_valid = 1'b0;
    tick;
    tick;
    chk("ucnt_near_top", 256'(uc), 256'hFFFE);
    bus.update_valid = 1'b1;
    repeat (3) tick;
    bus.update_valid = 1'b0;
    tick;
    tick;
    chk("ucnt_saturated", 256'(uc), 256'hFFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
